// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter: prepends 1..DATA_BYTE_WD header bytes to each packet and repacks into full beats.
// Define AXIS_INSERT_HEADER_ZERO_PAD_EN to force data_out bytes with keep_out=0 to 0x00.
module axi_stream_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert
);

    localparam int CNT_W = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WD-1:0]      residual;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        flush_cnt;
    logic                    out_free;
    logic                    hdr_fire;
    logic                    in_fire;
    logic [CNT_W-1:0]        l_cnt;
    logic [CNT_W:0]          sum_cnt;
    logic [CNT_W-1:0]        sum_lo;
    logic                    last_fits;
    logic [DATA_WD-1:0]      beat_data;
    logic [DATA_WD-1:0]      flush_data;
    logic                    load;
    logic [DATA_WD-1:0]      data_pre;
    logic [DATA_BYTE_WD-1:0] keep_pre;
    logic                    last_pre;
    logic [DATA_WD-1:0]      data_nxt;
    logic                    unused_keep_insert;

    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_W'(k[i]);
        return c;
    endfunction

    // MSB-aligned mask with the top n bits set
    function automatic logic [DATA_BYTE_WD-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [DATA_BYTE_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (CNT_W'(i) < n);
        return m;
    endfunction

    // Residual keeps its R valid bytes in the low end; shifting the pair right by R bytes
    // lines them up ahead of the first DATA_BYTE_WD-R bytes of the new beat.
    function automatic logic [DATA_WD-1:0] merge_beat(input logic [DATA_WD-1:0] res,
                                                     input logic [DATA_WD-1:0] din,
                                                     input logic [CNT_W-1:0]   r);
        logic [2*DATA_WD-1:0] cat;
        cat = {res, din} >> {r, 3'b000};
        return cat[DATA_WD-1:0];
    endfunction

`ifdef AXIS_INSERT_HEADER_ZERO_PAD_EN
    function automatic logic [DATA_WD-1:0] zero_pad(input logic [DATA_WD-1:0] d,
                                                   input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] r;
        r = d;
        for (int i = 0; i < DATA_BYTE_WD; i++) if (!k[i]) r[i*8 +: 8] = 8'h00;
        return r;
    endfunction
`endif

    assign unused_keep_insert = ^keep_insert;
    assign out_free   = !valid_out || ready_out;
    assign hdr_fire   = valid_insert && ready_insert;
    assign in_fire    = valid_in && ready_in;
    assign l_cnt      = popcount(keep_in);
    assign sum_cnt    = {1'b0, r_cnt} + {1'b0, l_cnt};
    assign sum_lo     = sum_cnt[CNT_W-1:0];
    assign last_fits  = sum_cnt <= (CNT_W+1)'(DATA_BYTE_WD);
    assign beat_data  = merge_beat(residual, data_in, r_cnt);
    assign flush_data = residual << {(CNT_W'(DATA_BYTE_WD) - r_cnt), 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ready_insert = 1'b0;
        ready_in     = 1'b0;
        case (state)
            IDLE: begin
                ready_insert = rst_n;
                if (valid_insert) state_nxt = DATA;
            end
            DATA: begin
                ready_in = rst_n && out_free;
                if (valid_in && out_free && last_in) state_nxt = last_fits ? IDLE : FLUSH;
            end
            FLUSH: begin
                if (out_free) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        data_pre = beat_data;
        keep_pre = '1;
        last_pre = 1'b0;
        if (in_fire) begin
            load = 1'b1;
            if (last_in && last_fits) begin
                keep_pre = keep_mask(sum_lo);
                last_pre = 1'b1;
            end
        end else if (state == FLUSH && out_free) begin
            load     = 1'b1;
            data_pre = flush_data;
            keep_pre = keep_mask(flush_cnt);
            last_pre = 1'b1;
        end
    end

`ifdef AXIS_INSERT_HEADER_ZERO_PAD_EN
    assign data_nxt = zero_pad(data_pre, keep_pre);
`else
    assign data_nxt = data_pre;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            residual  <= '0;
            r_cnt     <= '0;
            flush_cnt <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            if (hdr_fire) begin
                residual <= data_insert;
                r_cnt    <= {1'b0, byte_insert_cnt} + CNT_W'(1);
            end else if (in_fire) begin
                residual <= data_in;
            end
            if (in_fire && last_in && !last_fits) flush_cnt <= sum_lo - CNT_W'(DATA_BYTE_WD);
            if (load) begin
                valid_out <= 1'b1;
                data_out  <= data_nxt;
                keep_out  <= keep_pre;
                last_out  <= last_pre;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Scoreboard bench for axi_stream_insert_header: byte-queue reference model, random packets and directed cases.
module tb_axi_stream_insert_header;

    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int CW = $clog2(NB);

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [NB-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [NB-1:0] keep_out;
    logic          last_out;
    logic          ready_out;
    logic          valid_insert;
    logic [DW-1:0] data_insert;
    logic [NB-1:0] keep_insert;
    logic [CW-1:0] byte_insert_cnt;
    logic          ready_insert;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [NB-1:0] k;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          rand_rdy = 1'b0;
    logic          rdy_fix  = 1'b1;
    logic [DW-1:0] pay_data[16];
    int            last_len;

    axi_stream_insert_header #(.DATA_WD(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic logic [NB-1:0] kmask(input int l);
        logic [NB-1:0] k;
        k = '0;
        for (int j = 0; j < l; j++) k[NB-1-j] = 1'b1;
        return k;
    endfunction

    function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] k);
        logic [DW-1:0] m;
        for (int i = 0; i < NB; i++) m[i*8 +: 8] = k[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Reference: header bytes then payload bytes as one byte stream, cut into beats of NB.
    task automatic model_push(input int cnt, input logic [DW-1:0] hdr, input int nb);
        logic [7:0] q[$];
        exp_t       e;
        int         n;
        for (int i = cnt; i >= 0; i--) q.push_back(hdr[i*8 +: 8]);
        for (int b = 0; b < nb; b++) begin
            n = (b == nb - 1) ? last_len : NB;
            for (int j = 0; j < n; j++) q.push_back(pay_data[b][DW-1-8*j -: 8]);
        end
        while (q.size() > 0) begin
            e = '0;
            for (int j = 0; j < NB && q.size() > 0; j++) begin
                e.d[DW-1-8*j -: 8] = q.pop_front();
                e.k[NB-1-j] = 1'b1;
            end
            e.l = (q.size() == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
        exp_t e;
        e.d = d; e.k = k; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic send_header(input int cnt, input logic [DW-1:0] hdr);
        int n;
        data_insert     = hdr;
        byte_insert_cnt = CW'(cnt);
        keep_insert     = ~kmask(NB - cnt - 1);
        valid_insert    = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_insert) break;
            n++;
            if (n > 300) begin
                check("header_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
        int n;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        valid_in = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_in) break;
            n++;
            if (n > 300) begin
                check("beat_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic drive_pkt(input int cnt, input logic [DW-1:0] hdr, input int nb);
        send_header(cnt, hdr);
        for (int b = 0; b < nb; b++)
            send_beat(pay_data[b], (b == nb - 1) ? kmask(last_len) : '1, b == nb - 1);
    endtask

    task automatic rand_pkt(input logic push);
        int            cnt, nb;
        logic [DW-1:0] hdr;
        cnt      = $urandom_range(0, NB - 1);
        nb       = $urandom_range(1, 4);
        hdr      = $urandom;
        last_len = $urandom_range(1, NB);
        for (int b = 0; b < nb; b++) pay_data[b] = $urandom;
        if (push) model_push(cnt, hdr, nb);
        drive_pkt(cnt, hdr, nb);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            ready_out = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;
        end
    end

    // Output scoreboard: one entry consumed per transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {32'd0, data_out}, 64'd0);
            end else begin
                e = exp_q.pop_front();
`ifdef AXIS_INSERT_HEADER_ZERO_PAD_EN
                check("data_out", {32'd0, data_out}, {32'd0, e.d});
`else
                check("data_out", {32'd0, data_out & byte_mask(e.k)}, {32'd0, e.d});
`endif
                check("keep_out", {60'd0, keep_out}, {60'd0, e.k});
                check("last_out", {63'd0, last_out}, {63'd0, e.l});
            end
        end
    end

    // Output stability under backpressure and no payload acceptance while the slot is full
    logic          prev_hold = 1'b0;
    logic          prev_rst  = 1'b0;
    logic [DW-1:0] prev_data;
    logic [NB-1:0] prev_keep;
    logic          prev_last;
    always @(negedge clk) begin
        if (rst_n && prev_rst && prev_hold) begin
            check("hold_valid", {63'd0, valid_out}, 64'd1);
            check("hold_data", {32'd0, data_out}, {32'd0, prev_data});
            check("hold_keep_last", {59'd0, keep_out, last_out}, {59'd0, prev_keep, prev_last});
        end
        if (rst_n && valid_out && !ready_out) check("ready_in_stall", {63'd0, ready_in}, 64'd0);
        prev_hold = valid_out && !ready_out;
        prev_rst  = rst_n;
        prev_data = data_out;
        prev_keep = keep_out;
        prev_last = last_out;
    end

    initial begin
        int n;
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
        ready_out = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {valid_out, last_out, keep_out, 26'd0, data_out}, 64'd0);
        check("rst_ready", {62'd0, ready_in, ready_insert}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_insert_after_rst", {63'd0, ready_insert}, 64'd1);
        @(posedge clk); #1;

        // Two-byte header, payload ends with two bytes
        push_exp(32'hCCDD1122, 4'hF, 1'b0);
        push_exp(32'h33445566, 4'hF, 1'b1);
        pay_data[0] = 32'h11223344; pay_data[1] = 32'h55667788; last_len = 2;
        drive_pkt(1, 32'hAABBCCDD, 2);

        // Full-word header, one-byte single beat
        push_exp(32'hA1A2A3A4, 4'hF, 1'b0);
        push_exp(32'h01000000, 4'h8, 1'b1);
        pay_data[0] = 32'h01020304; last_len = 1;
        drive_pkt(3, 32'hA1A2A3A4, 1);

        // One-byte header overflowing into a flush beat
        push_exp(32'hEE112233, 4'hF, 1'b0);
        push_exp(32'h44556677, 4'hF, 1'b0);
        push_exp(32'h88000000, 4'h8, 1'b1);
        pay_data[0] = 32'h11223344; pay_data[1] = 32'h55667788; last_len = 4;
        drive_pkt(0, 32'h000000EE, 2);

        // Three-cycle backpressure in the middle of a packet
        pay_data[0] = 32'hDEADBEEF; pay_data[1] = 32'h01234567; pay_data[2] = 32'h89ABCDEF;
        last_len = 3;
        model_push(2, 32'h00C0FFEE, 3);
        fork
            drive_pkt(2, 32'h00C0FFEE, 3);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!valid_out && n < 200);
                rdy_fix = 1'b0;
                repeat (3) @(posedge clk);
                rdy_fix = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Payload offered before any header must stall
        pay_data[0] = 32'h5A5B5C5D; last_len = 4;
        model_push(1, 32'h0000F00D, 1);
        data_in = 32'h5A5B5C5D; keep_in = 4'hF; last_in = 1'b1; valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_hdr_ready_in", {63'd0, ready_in}, 64'd0);
            check("no_hdr_valid_out", {63'd0, valid_out}, 64'd0);
        end
        @(posedge clk); #1;
        send_header(1, 32'h0000F00D);
        send_beat(32'h5A5B5C5D, 4'hF, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Reset in the middle of a packet with its first beat stuck on the output
        rdy_fix = 1'b0;
        @(posedge clk); #1;
        send_header(1, 32'h12345678);
        send_beat(32'hCAFEF00D, 4'hF, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {valid_out, last_out, keep_out, 26'd0, data_out}, 64'd0);
        check("midrst_ready_insert", {63'd0, ready_insert}, 64'd1);
        rdy_fix = 1'b1;
        @(posedge clk); #1;
        rand_pkt(1'b1);

        // Random packets under random backpressure
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) rand_pkt(1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
